// File: rtl/seven_seg_scanner_if.sv
// Core-to-display bus: write strobe/data in, scanned segment drive and status out.
interface seven_seg_scanner_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  seg;
  logic [6:0]  display;
  logic        pending;
  logic        frame_done;

  modport master (output wr_en, wr_data, input seg, display, pending, frame_done);
  modport slave  (input wr_en, wr_data, output seg, display, pending, frame_done);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display driver with frame-boundary double buffering
// and optional leading-zero blanking.
module seven_seg_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 25000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scanner_if.slave   bus
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   shown_q, shown_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          pending_q, pending_d;
  logic [7:0]    seg_q, seg_d;
  logic [6:0]    display_q, display_d;

  logic          tick, boundary, upper_zero, blank;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Scan timing and buffer transfer
  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    shown_d     = shown_q;
    pend_data_d = pend_data_q;
    pending_d   = pending_q;
    // Boundary moves the pre-write value; a same-cycle write then re-arms pending.
    if (boundary && pending_q) begin
      shown_d   = pend_data_q;
      pending_d = 1'b0;
    end
    if (bus.wr_en) begin
      pend_data_d = bus.wr_data;
      pending_d   = 1'b1;
    end
  end

  // Digit drive for the current index, registered one cycle later
  always_comb begin
    nibble     = shown_q[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < 8; j++)
      if (j < NUM_DIGITS && j >= int'(idx_q) && shown_q[4*j +: 4] != 4'h0)
        upper_zero = 1'b0;
    blank     = (BLANK_LEADING != 0) && (idx_q != '0) && upper_zero;
    seg_d     = blank ? 8'hFF : ~(8'h01 << idx_q);
    display_d = blank ? 7'h7F : hex7(nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      shown_q     <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      seg_q       <= 8'hFF;
      display_q   <= 7'h7F;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      shown_q     <= shown_d;
      pend_data_q <= pend_data_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      display_q   <= display_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.display    = display_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = boundary;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs,
// a negedge monitor pops and compares; blanking on and off run side by side.
module tb_seven_seg_scanner;
  localparam int ND = 8;
  localparam int RD = 4;
  localparam int FRAME = ND * RD;

  logic        clk, rst, wr_en;
  logic [31:0] wr_data;

  seven_seg_scanner_if bus_a ();
  seven_seg_scanner_if bus_b ();
  assign bus_a.wr_en = wr_en;  assign bus_a.wr_data = wr_data;
  assign bus_b.wr_en = wr_en;  assign bus_b.wr_data = wr_data;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg_a;  logic [6:0] disp_a;
    logic [7:0] seg_b;  logic [6:0] disp_b;
    logic       pend;   logic       fd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: cycles since reset, displayed word, buffered word.
  int          k;
  logic [31:0] m_shown, m_pv;
  bit          m_pend;
  logic [7:0]  o_seg_a, o_seg_b;
  logic [6:0]  o_disp_a, o_disp_b;

  function automatic void digit_out(input logic [31:0] sh, input int d, input bit bl,
                                    output logic [7:0] s, output logic [6:0] dp);
    logic [31:0] upper;
    logic [7:0]  one;
    upper = sh >> (4 * d);
    one   = 8'h01;
    if (bl && d > 0 && upper == 32'h0) begin
      s  = 8'hFF;
      dp = 7'h7F;
    end else begin
      s  = ~(one << d);
      dp = hex_tab[upper[3:0]];
    end
  endfunction

  task automatic model_reset();
    k = 0; m_shown = 0; m_pv = 0; m_pend = 0;
    o_seg_a = 8'hFF; o_seg_b = 8'hFF; o_disp_a = 7'h7F; o_disp_b = 7'h7F;
  endtask

  task automatic step(input bit w, input logic [31:0] data);
    exp_t e;
    bit   fd;
    int   d;
    fd = (k % FRAME) == FRAME - 1;
    e.seg_a = o_seg_a; e.disp_a = o_disp_a;
    e.seg_b = o_seg_b; e.disp_b = o_disp_b;
    e.pend  = m_pend;  e.fd     = fd;
    sb.push_back(e);
    wr_en = w; wr_data = data;
    d = (k / RD) % ND;
    digit_out(m_shown, d, 1'b1, o_seg_a, o_disp_a);
    digit_out(m_shown, d, 1'b0, o_seg_b, o_disp_b);
    if (fd && m_pend) begin m_shown = m_pv; m_pend = 0; end
    if (w) begin m_pv = data; m_pend = 1; end
    k++;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic run_to(input int phase);
    while (k % FRAME != phase) step(1'b0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("seg_blank",      32'(bus_a.seg),        32'(e.seg_a));
        chk("display_blank",  32'(bus_a.display),    32'(e.disp_a));
        chk("seg_noblank",    32'(bus_b.seg),        32'(e.seg_b));
        chk("display_noblank",32'(bus_b.display),    32'(e.disp_b));
        chk("pending",        32'(bus_a.pending),    32'(e.pend));
        chk("frame_done",     32'(bus_a.frame_done), 32'(e.fd));
        chk("pending_b",      32'(bus_b.pending),    32'(e.pend));
        chk("frame_done_b",   32'(bus_b.frame_done), 32'(e.fd));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; wr_en = 1'b0; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    run(70);                                  // idle frames, value 0
    run_to(10);  step(1'b1, 32'h89ABCDEF);    // mid-frame write
    run(2 * FRAME);
    run_to(5);   step(1'b1, 32'h00000105);    // leading blanking
    run(2 * FRAME);
    run_to(3);   step(1'b1, 32'h22222222);    // write on boundary with value pending
    run_to(FRAME - 1); step(1'b1, 32'h11111111);
    run(2 * FRAME + 5);
    run_to(4);   step(1'b1, 32'h3);           // last write in a frame wins
    run(6);      step(1'b1, 32'h7);
    run(FRAME + 16);
    run_to(21);  step(1'b1, 32'hDEADBEEF);    // reset during digit 5, write pending
    run(1);
    do_reset();
    run(FRAME + 8);

    for (int i = 0; i < 700; i++) begin
      if ((k % FRAME == FRAME - 1 && $urandom_range(0, 1) == 1) || $urandom_range(0, 9) == 0)
        step(1'b1, $urandom >> (4 * $urandom_range(0, 7)));
      else
        step(1'b0, 32'h0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    run(2 * FRAME);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
